alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
// Issue/retire stage in front of the 16-bit ALU datapath. Accepts one operation
// (opcode + two 16-bit operands) per valid/ready handshake, drives operands and
// the one-hot Mux16 select into the ALU, waits a fixed settle time, and captures
// the 32-bit Mux16 output plus status flags into a result register offered
// downstream on a second valid/ready handshake. Exactly one operation in flight.
// PARAMETERS
// EXEC_CYCLES  2   cycles op_sel is held before capture (>=1; ALU settle time)
// PORTS
// clk          in   1   rising-edge clock, only clock
// clr          in   1   asynchronous, active-low reset
// in_valid     in   1   upstream offers op
// in_ready     out  1   block can accept op (high only in IDLE)
// in_op        in   4   opcode: 0 ADD 1 SUB 2 MULT 3 DIV 4 SLL 5 SRL 6 AND 7 OR
//                       8 XOR 9 NOT 10 NAND 11 NOR; 12-15 reserved
// in_a, in_b   in   16  operands
// alu_a, alu_b out  16  registered operands to ALU sub-blocks
// op_sel       out  16  one-hot Mux16 select, bit n = opcode n
// alu_result   in   32  Mux16 output
// alu_ovf      in   1   ADD overflow (out[16])
// out_valid    out  1   result register holds unread result
// out_ready    in   1   downstream accepts result
// out_result   out  32  captured result
// out_zero     out  1   out_result == 0
// out_ovf      out  1   ADD: alu_ovf; SUB: borrow (a<b); else 0
// out_div0     out  1   DIV with b==0
// out_illegal  out  1   reserved opcode
// op_count     out  16  completed (retired) ops, wraps 16'hFFFF->0
// BEHAVIOUR
// - clr low (any time, async): state IDLE; every output above = 0 except
//   in_ready = 0 while clr low, 1 from first edge after release. In-flight op
//   and any unread result are discarded; op_count = 0.
// - FSM IDLE -> EXEC -> HOLD -> IDLE.
//   IDLE: in_ready=1, op_sel=0. On in_valid: latch in_a/in_b into alu_a/alu_b,
//     latch opcode, load cnt=EXEC_CYCLES-1, go EXEC.
//   EXEC: in_ready=0. op_sel=one-hot(opcode) held stable; op_sel=0 if opcode
//     reserved or (DIV and alu_b==0). If cnt!=0: cnt-1. If cnt==0: capture
//     result+flags, go HOLD.
//   HOLD: out_valid=1, outputs frozen. On out_ready: out_valid=0,
//     op_count+1, go IDLE. in_valid ignored in EXEC and HOLD.
// - Latency: accept edge k -> out_valid high after edge k+EXEC_CYCLES;
//   next op acceptable at edge following out handshake (no same-cycle overlap).
// - Capture rules: normal op: out_result=alu_result. Reserved: out_result=0,
//   out_illegal=1. DIV b==0: out_result=32'hFFFF_FFFF, out_div0=1.
//   out_zero computed on final out_result. Flags mutually consistent per op.
// - SUB borrow from latched operands ({1'b0,a}<{1'b0,b}); alu_ovf sampled
//   only on capture cycle.
// - out_result/flags hold last value after retire until next capture.
// - alu_a/alu_b change only on accept; op_sel never glitches within EXEC.
// TESTING
// - ADD a=16'hFFFF b=16'h0001, EXEC_CYCLES=2 -> out_valid 2 edges after accept,
//   out_result=32'h0001_0000, out_ovf=1, out_zero=0, op_sel=16'h0001 in EXEC.
// - SUB a=3 b=5 -> out_result=32'hFFFF_FFFE, out_ovf=1; a=5 b=5 -> 0, out_zero=1.
// - DIV a=100 b=0 -> op_sel=0 throughout, out_result=32'hFFFF_FFFF,
//   out_div0=1; DIV a=100 b=7 -> out_result=14, out_div0=0.
// - opcode 13 -> out_illegal=1, out_result=0, out_zero=1; op_count increments.
// - Backpressure: hold out_ready=0 10 cycles with in_valid=1 -> in_ready=0,
//   result stable, no second accept; out_ready=1 -> retire, accept next edge.
// - clr pulse low mid-EXEC -> all outputs 0 immediately, op_count=0, no
//   out_valid for discarded op; op_count wraps 16'hFFFF -> 0 after 65536 ops.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/retire stage in front of the 16-bit ALU datapath. Accepts one
// operation per valid/ready handshake, drives registered operands and a
// one-hot Mux16 select into the ALU, waits EXEC_CYCLES for the datapath to
// settle, then captures the Mux16 output plus status flags into a result
// register offered downstream. Exactly one operation is in flight.
//
// Ports
//   clk          rising-edge clock
//   clr          asynchronous active-low reset
//   in_valid     upstream offers an op          in_ready   op can be accepted
//   in_op        opcode (0..11 legal)           in_a/in_b  operands
//   alu_a/alu_b  registered operands to ALU     op_sel     one-hot Mux16 select
//   alu_result   Mux16 output                   alu_ovf    ADD carry-out
//   out_valid    unread result held             out_ready  downstream accepts
//   out_result   captured result                out_zero   out_result == 0
//   out_ovf      ADD carry / SUB borrow         out_div0   DIV by zero
//   out_illegal  reserved opcode                op_count   retired ops (wraps)
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int unsigned EXEC_CYCLES = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [15:0] op_sel,
   input  logic [31:0] alu_result,
   input  logic        alu_ovf,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic        out_ovf,
   output logic        out_div0,
   output logic        out_illegal,
   output logic [15:0] op_count
);

   localparam int unsigned CW = $clog2(EXEC_CYCLES) + 1;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_DIV = 4'd3;

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [3:0]      op_q;
   logic [15:0]     a_q, b_q, op_sel_q, op_count_q;
   logic            in_ready_q, out_valid_q;
   logic [31:0]     result_q;
   logic            zero_q, ovf_q, div0_q, illegal_q;

   // Next-value terms for the select (from the incoming op) and the capture
   // (from the latched op).
   logic [15:0]     sel_d;
   logic [31:0]     result_d;
   logic            ovf_d, div0_d, illegal_d;

   // NOTE: every signal written here gets a default first so no latch is
   // inferred on any path through the block.
   always_comb begin
      sel_d     = '0;
      result_d  = alu_result;
      ovf_d     = 1'b0;
      div0_d    = 1'b0;
      illegal_d = 1'b0;

      // Reserved opcodes and divide-by-zero never drive the Mux16.
      if (in_op[3:2] != 2'b11 && !(in_op == OP_DIV && in_b == 16'h0000))
         sel_d = 16'h0001 << in_op;

      if (op_q[3:2] == 2'b11) begin
         illegal_d = 1'b1;
         result_d  = '0;
      end else if (op_q == OP_DIV && b_q == 16'h0000) begin
         div0_d   = 1'b1;
         result_d = 32'hFFFF_FFFF;
      end else if (op_q == OP_ADD) begin
         ovf_d = alu_ovf;
      end else if (op_q == OP_SUB) begin
         ovf_d = ({1'b0, a_q} < {1'b0, b_q});
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_sel_q    <= '0;
         op_count_q  <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         div0_q      <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  op_q       <= in_op;
                  op_sel_q   <= sel_d;
                  cnt_q      <= CW'(EXEC_CYCLES - 1);
                  in_ready_q <= 1'b0;
                  state_q    <= EXEC;
               end else begin
                  // First edge after reset release raises in_ready.
                  in_ready_q <= 1'b1;
               end
            end
            EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  result_q    <= result_d;
                  zero_q      <= (result_d == 32'h0);
                  ovf_q       <= ovf_d;
                  div0_q      <= div0_d;
                  illegal_q   <= illegal_d;
                  op_sel_q    <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  op_count_q  <= op_count_q + 16'd1;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign op_sel      = op_sel_q;
   assign out_valid   = out_valid_q;
   assign out_result  = result_q;
   assign out_zero    = zero_q;
   assign out_ovf     = ovf_q;
   assign out_div0    = div0_q;
   assign out_illegal = illegal_q;
   assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl. A behavioural ALU/Mux16 answers the
// registered operands and select; expected results are hand-computed.
// Outputs are sampled on the falling edge, inputs driven there too.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        clr;
   logic        in_valid, in_ready;
   logic [3:0]  in_op;
   logic [15:0] in_a, in_b, alu_a, alu_b, op_sel, op_count;
   logic [31:0] alu_result, out_result;
   logic        alu_ovf, out_valid, out_ready;
   logic        out_zero, out_ovf, out_div0, out_illegal;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_count = '0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.EXEC_CYCLES(2)) dut (
      .clk(clk), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b),
      .alu_a(alu_a), .alu_b(alu_b), .op_sel(op_sel),
      .alu_result(alu_result), .alu_ovf(alu_ovf),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_ovf(out_ovf), .out_div0(out_div0),
      .out_illegal(out_illegal), .op_count(op_count)
   );

   // Behavioural ALU datapath; an unselected Mux16 returns junk so the
   // controller's overrides are visible.
   always_comb begin
      case (op_sel)
         16'h0001: alu_result = {16'h0, alu_a} + {16'h0, alu_b};
         16'h0002: alu_result = {16'h0, alu_a} - {16'h0, alu_b};
         16'h0004: alu_result = {16'h0, alu_a} * {16'h0, alu_b};
         16'h0008: alu_result = (alu_b == 16'h0) ? 32'h0 : {16'h0, alu_a / alu_b};
         16'h0010: alu_result = {16'h0, alu_a} << alu_b[3:0];
         16'h0020: alu_result = {16'h0, alu_a >> alu_b[3:0]};
         16'h0040: alu_result = {16'h0, alu_a & alu_b};
         16'h0080: alu_result = {16'h0, alu_a | alu_b};
         16'h0100: alu_result = {16'h0, alu_a ^ alu_b};
         16'h0200: alu_result = {16'h0, ~alu_a};
         16'h0400: alu_result = {16'h0, ~(alu_a & alu_b)};
         16'h0800: alu_result = {16'h0, ~(alu_a | alu_b)};
         default:  alu_result = 32'hDEAD_BEEF;
      endcase
      alu_ovf = alu_result[16];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full op: accept, two EXEC cycles, check capture, retire.
   // exp_flags = {zero, ovf, div0, illegal}.
   task automatic do_op(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_sel,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags);
      int n = 0;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "/ready"}, 32'(in_ready), 32'd1);
      next_cycle();
      in_valid = 1'b0; in_a = 16'h5A5A; in_b = 16'hA5A5;
      check({name, "/sel_e1"}, 32'(op_sel), 32'(exp_sel));
      check({name, "/alu_a"}, 32'(alu_a), 32'(a));
      check({name, "/alu_b"}, 32'(alu_b), 32'(b));
      check({name, "/rdy_e1"}, 32'(in_ready), 32'd0);
      check({name, "/vld_e1"}, 32'(out_valid), 32'd0);
      next_cycle();
      check({name, "/sel_e2"}, 32'(op_sel), 32'(exp_sel));
      check({name, "/vld_e2"}, 32'(out_valid), 32'd0);
      next_cycle();
      check({name, "/vld_h"}, 32'(out_valid), 32'd1);
      check({name, "/result"}, out_result, exp_res);
      check({name, "/flags"}, 32'({out_zero, out_ovf, out_div0, out_illegal}), 32'(exp_flags));
      out_ready = 1'b1;
      next_cycle();
      out_ready = 1'b0;
      exp_count = exp_count + 16'd1;
      check({name, "/vld_r"}, 32'(out_valid), 32'd0);
      check({name, "/count"}, 32'(op_count), 32'(exp_count));
      check({name, "/rdy_r"}, 32'(in_ready), 32'd1);
      check({name, "/hold"}, out_result, exp_res);
   endtask

   initial begin
      clr = 1'b0; in_valid = 1'b1; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
      #12;
      check("rst/ready", 32'(in_ready), 32'd0);
      check("rst/valid", 32'(out_valid), 32'd0);
      check("rst/sel", 32'(op_sel), 32'd0);
      check("rst/count", 32'(op_count), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      check("rel/ready_pre", 32'(in_ready), 32'd0);
      next_cycle();
      check("rel/ready_post", 32'(in_ready), 32'd1);

      do_op("add_ovf",  4'd0,  16'hFFFF, 16'h0001, 16'h0001, 32'h0001_0000, 4'b0100);
      do_op("sub_brw",  4'd1,  16'd3,    16'd5,    16'h0002, 32'hFFFF_FFFE, 4'b0100);
      do_op("sub_zero", 4'd1,  16'd5,    16'd5,    16'h0002, 32'h0000_0000, 4'b1000);
      do_op("div0",     4'd3,  16'd100,  16'd0,    16'h0000, 32'hFFFF_FFFF, 4'b0010);
      do_op("div7",     4'd3,  16'd100,  16'd7,    16'h0008, 32'd14,        4'b0000);
      do_op("rsv13",    4'd13, 16'h1234, 16'h5678, 16'h0000, 32'h0000_0000, 4'b1001);
      do_op("mult",     4'd2,  16'h0100, 16'h0100, 16'h0004, 32'h0001_0000, 4'b0000);
      do_op("xor",      4'd8,  16'h00FF, 16'h0F0F, 16'h0100, 32'h0000_0FF0, 4'b0000);
      do_op("not",      4'd9,  16'h1234, 16'h0000, 16'h0200, 32'h0000_EDCB, 4'b0000);
      do_op("sll",      4'd4,  16'h0001, 16'h0004, 16'h0010, 32'h0000_0010, 4'b0000);

      // Backpressure: AND result held for 10 cycles while OR is offered.
      in_valid = 1'b1; in_op = 4'd6; in_a = 16'hF0F0; in_b = 16'h3C3C;
      next_cycle();
      in_op = 4'd7; in_a = 16'h00F0; in_b = 16'h0F00;
      next_cycle();
      next_cycle();
      check("bp/valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         check("bp/ready", 32'(in_ready), 32'd0);
         check("bp/stable", out_result, 32'h0000_3030);
         check("bp/alu_a", 32'(alu_a), 32'h0000_F0F0);
         next_cycle();
      end
      out_ready = 1'b1;
      next_cycle();
      out_ready = 1'b0;
      exp_count = exp_count + 16'd1;
      check("bp/retire", 32'(out_valid), 32'd0);
      check("bp/count", 32'(op_count), 32'(exp_count));
      check("bp/ready_r", 32'(in_ready), 32'd1);
      next_cycle();
      in_valid = 1'b0;
      check("bp/next_a", 32'(alu_a), 32'h0000_00F0);
      check("bp/next_sel", 32'(op_sel), 32'h0000_0080);
      check("bp/next_rdy", 32'(in_ready), 32'd0);
      next_cycle();
      next_cycle();
      check("bp/or_res", out_result, 32'h0000_0FF0);
      out_ready = 1'b1;
      next_cycle();
      out_ready = 1'b0;
      exp_count = exp_count + 16'd1;
      check("bp/or_count", 32'(op_count), 32'(exp_count));

      // Reset pulse in the middle of EXEC discards the op.
      in_valid = 1'b1; in_op = 4'd0; in_a = 16'd1; in_b = 16'd2;
      next_cycle();
      in_valid = 1'b0;
      check("clr/sel_pre", 32'(op_sel), 32'h0000_0001);
      #1 clr = 1'b0;
      #1;
      exp_count = '0;
      check("clr/sel", 32'(op_sel), 32'd0);
      check("clr/alu_a", 32'(alu_a), 32'd0);
      check("clr/result", out_result, 32'd0);
      check("clr/ready", 32'(in_ready), 32'd0);
      check("clr/count", 32'(op_count), 32'd0);
      check("clr/flags", 32'({out_zero, out_ovf, out_div0, out_illegal, out_valid}), 32'd0);
      @(negedge clk);
      clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         check("clr/no_valid", 32'(out_valid), 32'd0);
      end
      do_op("post_clr", 4'd0, 16'd2, 16'd3, 16'h0001, 32'd5, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
